uart_rx_cfg: RTL

Runtime-configurable UART receiver and the successor to the fixed 8N1 receiver.
- Generalised in data width, with runtime parity mode (none/even/odd) and 1 or 2 stop bits.
- Adds 3-sample majority voting, break detection and per-byte error tagging.
- Sits between the RX pad and the ALU command path, and drives a single-entry AXI-Stream master.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx_cfg.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
//   parity_e   : runtime parity mode latched at frame start
//   rx_state_e : receiver FSM states
package uart_pkg;

  localparam int unsigned OVERSAMPLE   = 8;
  localparam int unsigned TUSER_FRAME  = 0;
  localparam int unsigned TUSER_PARITY = 1;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// N-stage synchroniser that resets to 1 (idle line level).
//   clk_i, reset_i : clock, async active-high reset
//   d_i            : asynchronous input
//   q_o            : synchronised output
module uart_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sync_q <= '1;
    else         sync_q <= sync_d;
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with 3-sample majority voting, break
// detection and a single-entry AXI-Stream output register.
//   clk_i, reset_i      : clock, async active-high reset
//   rx_i                : serial line (idle high)
//   m_axis_*            : received byte, tuser = {parity_err, frame_err}
//   cfg_prescale_i      : bit period = 8*prescale clocks (0 treated as 1)
//   cfg_parity_i        : 00/11 none, 01 even, 10 odd
//   cfg_stop2_i         : two stop bits when set
//   rx_busy             : frame in progress (any state but IDLE)
//   overrun_error       : pulse when a committed byte is dropped
//   break_det           : pulse when a break frame is committed
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      rx_i,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [1:0]                m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale_i,
  input  logic [1:0]                cfg_parity_i,
  input  logic                      cfg_stop2_i,
  output logic                      rx_busy,
  output logic                      overrun_error,
  output logic                      break_det
);

  localparam int unsigned CNT_W = PRESCALE_WIDTH + $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic rxs;

  uart_sync #(.N(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (rx_i),
    .q_o     (rxs)
  );

  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic                      stop_idx_q, stop_idx_d;
  logic [DATA_WIDTH-1:0]     sh_q, sh_d;
  logic                      s0_q, s0_d, s1_q, s1_d;
  logic                      par_err_q, par_err_d;
  logic                      frame_err_q, frame_err_d;
  logic                      par_bit_q, par_bit_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  parity_e                   par_mode_q, par_mode_d;
  logic                      stop2_q, stop2_d;

  logic [DATA_WIDTH-1:0]     tdata_q, tdata_d;
  logic [1:0]                tuser_q, tuser_d;
  logic                      tvalid_q, tvalid_d;
  logic                      busy_q, busy_d;
  logic                      ovr_q, ovr_d;
  logic                      brk_q, brk_d;

  logic [CNT_W-1:0] quarter_c, per_last_c;
  logic             samp0_c, samp1_c, dec_pt_c, bit_end_c;
  logic             dec_c, exp_par_c, fe_c, brk_c, commit_c;

  // Bit timing derived from the latched prescale: samples at 4p-1, 4p, 4p+1.
  always_comb begin
    quarter_c  = CNT_W'({presc_q, 2'b00});
    per_last_c = CNT_W'({presc_q, 3'b000}) - CNT_W'(1);
    samp0_c    = (cnt_q == quarter_c - CNT_W'(1));
    samp1_c    = (cnt_q == quarter_c);
    dec_pt_c   = (cnt_q == quarter_c + CNT_W'(1));
    bit_end_c  = (cnt_q == per_last_c);
    dec_c      = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    exp_par_c  = (par_mode_q == PAR_ODD) ? ~(^sh_q) : ^sh_q;
    fe_c       = frame_err_q | ~dec_c;
    brk_c      = fe_c && (sh_q == '0) && ((par_mode_q == PAR_NONE) || !par_bit_q);
  end

  // Receiver FSM and datapath next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    sh_d        = sh_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    par_bit_d   = par_bit_q;
    presc_d     = presc_q;
    par_mode_d  = par_mode_q;
    stop2_d     = stop2_q;
    commit_c    = 1'b0;

    if (state_q != IDLE && state_q != BREAK_WAIT) begin
      cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
      if (samp0_c) s0_d = rxs;
      if (samp1_c) s1_d = rxs;
    end

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d     = START;
          cnt_d       = '0;
          bit_idx_d   = '0;
          stop_idx_d  = 1'b0;
          par_err_d   = 1'b0;
          frame_err_d = 1'b0;
          par_bit_d   = 1'b0;
          presc_d     = (cfg_prescale_i == '0) ? PRESCALE_WIDTH'(1) : cfg_prescale_i;
          stop2_d     = cfg_stop2_i;
          case (cfg_parity_i)
            2'b01:   par_mode_d = PAR_EVEN;
            2'b10:   par_mode_d = PAR_ODD;
            default: par_mode_d = PAR_NONE;
          endcase
        end
      end
      START: begin
        if (dec_pt_c && dec_c) state_d = IDLE;
        else if (bit_end_c)    state_d = DATA;
      end
      DATA: begin
        if (dec_pt_c) sh_d = {dec_c, sh_q[DATA_WIDTH-1:1]};
        if (bit_end_c) begin
          if (bit_idx_q == LAST_IDX) state_d = (par_mode_q != PAR_NONE) ? PARITY : STOP;
          else                       bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      PARITY: begin
        if (dec_pt_c) begin
          par_bit_d = dec_c;
          par_err_d = (dec_c != exp_par_c);
        end
        if (bit_end_c) state_d = STOP;
      end
      STOP: begin
        // Final stop commits at its decision point so the next start can resync.
        if (dec_pt_c) begin
          frame_err_d = fe_c;
          if (stop_idx_q == stop2_q) begin
            commit_c = 1'b1;
            state_d  = brk_c ? BREAK_WAIT : IDLE;
          end
        end else if (bit_end_c) begin
          stop_idx_d = 1'b1;
        end
      end
      BREAK_WAIT: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output holding register and status pulses.
  always_comb begin
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    ovr_d    = 1'b0;
    brk_d    = 1'b0;
    busy_d   = (state_d != IDLE);
    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
    if (commit_c) begin
      brk_d = brk_c;
      if (!tvalid_q || m_axis_tready) begin
        tvalid_d              = 1'b1;
        tdata_d               = sh_q;
        tuser_d[TUSER_PARITY] = par_err_q;
        tuser_d[TUSER_FRAME]  = fe_c;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      sh_q        <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      par_bit_q   <= 1'b0;
      presc_q     <= PRESCALE_WIDTH'(1);
      par_mode_q  <= PAR_NONE;
      stop2_q     <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= '0;
      tvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      sh_q        <= sh_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      par_bit_q   <= par_bit_d;
      presc_q     <= presc_d;
      par_mode_q  <= par_mode_d;
      stop2_q     <= stop2_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tvalid_q    <= tvalid_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      brk_q       <= brk_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign rx_busy       = busy_q;
  assign overrun_error = ovr_q;
  assign break_det     = brk_q;

endmodule
